// File: rtl/spi_flash_xip_slave.sv
// SPI NOR-flash READ responder (mode 0) streaming bytes from a word-wide backing memory.
// Optional `SPI_FLASH_FAST_READ_EN adds FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_xip_slave #(
  parameter int unsigned MEM_AW   = 22,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              spi_sck,
  input  logic              spi_ss,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              flash_ren,
  output logic [MEM_AW-1:0] flash_raddr,
  input  logic [31:0]       flash_rdata
);

  // state    | meaning
  // S_IDLE   | waiting for a falling spi_ss
  // S_CMD    | shifting in the 8-bit opcode
  // S_ADDR   | shifting in the 24-bit byte address
  // S_DUMMY  | fast read only: 8 ignored clocks before data
  // S_DATA   | streaming bytes on miso, prefetching the next word
  // S_IGNORE | unsupported opcode, silent until deselect
  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_IGNORE
  } state_t;

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] FAST_CMD = 8'h0B;
  logic fast_q;
`endif

  state_t            state;
  logic              sck_q;
  logic              ss_q;
  logic [4:0]        bit_cnt;
  logic [22:0]       shift_sr;
  logic [1:0]        byte_idx;
  logic [MEM_AW-1:0] wa_q;
  logic [31:0]       cur_word;
  logic [31:0]       next_word;
  logic              pend_cur;
  logic              pend_next;

  logic              rise;
  logic              fall;
  logic [23:0]       addr_next;
  logic              first_rd;
  logic              pref_rd;
  logic [7:0]        cur_byte;

  always_comb begin
    rise      = spi_sck & ~sck_q;
    fall      = ~spi_sck & sck_q;
    addr_next = {shift_sr, spi_mosi};
    first_rd  = (state == S_ADDR) && !spi_ss && rise && (bit_cnt == 5'd23);
    // Fetch word+1 while the last byte of the current word is being shifted out
    pref_rd   = (state == S_DATA) && !spi_ss && fall && (bit_cnt == 5'd0) && (byte_idx == 2'd3);
    flash_ren = first_rd | pref_rd;
    if (first_rd)
      flash_raddr = MEM_AW'(addr_next[23:2]);
    else if (pref_rd)
      flash_raddr = wa_q + MEM_AW'(1);
    else
      flash_raddr = wa_q;
    cur_byte = cur_word[{byte_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      sck_q     <= 1'b0;
      ss_q      <= 1'b0;
      bit_cnt   <= '0;
      shift_sr  <= '0;
      byte_idx  <= '0;
      wa_q      <= '0;
      cur_word  <= '0;
      next_word <= '0;
      pend_cur  <= 1'b0;
      pend_next <= 1'b0;
      spi_miso  <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
      fast_q    <= 1'b0;
`endif
    end else begin
      sck_q <= spi_sck;
      ss_q  <= spi_ss;
      if (spi_ss) begin
        state     <= S_IDLE;
        spi_miso  <= 1'b0;
        bit_cnt   <= '0;
        pend_cur  <= 1'b0;
        pend_next <= 1'b0;
      end else begin
        pend_cur  <= first_rd;
        pend_next <= pref_rd;
        if (pend_cur)
          cur_word <= flash_rdata;
        if (pend_next)
          next_word <= flash_rdata;
        case (state)
          S_IDLE: begin
            spi_miso <= 1'b0;
            if (ss_q) begin
              state   <= S_CMD;
              bit_cnt <= '0;
`ifdef SPI_FLASH_FAST_READ_EN
              fast_q  <= 1'b0;
`endif
            end
          end
          S_CMD: begin
            if (rise) begin
              shift_sr <= addr_next[22:0];
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                if (addr_next[7:0] == READ_CMD)
                  state <= S_ADDR;
`ifdef SPI_FLASH_FAST_READ_EN
                else if (addr_next[7:0] == FAST_CMD) begin
                  state  <= S_ADDR;
                  fast_q <= 1'b1;
                end
`endif
                else
                  state <= S_IGNORE;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_ADDR: begin
            if (rise) begin
              shift_sr <= addr_next[22:0];
              if (bit_cnt == 5'd23) begin
                bit_cnt  <= '0;
                byte_idx <= addr_next[1:0];
                wa_q     <= MEM_AW'(addr_next[23:2]);
`ifdef SPI_FLASH_FAST_READ_EN
                state    <= fast_q ? S_DUMMY : S_DATA;
`else
                state    <= S_DATA;
`endif
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`ifdef SPI_FLASH_FAST_READ_EN
          S_DUMMY: begin
            if (rise) begin
              if (bit_cnt == 5'd7) begin
                bit_cnt <= '0;
                state   <= S_DATA;
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
`endif
          S_DATA: begin
            if (fall) begin
              spi_miso <= cur_byte[3'd7 - bit_cnt[2:0]];
              if (bit_cnt == 5'd7) begin
                bit_cnt  <= '0;
                byte_idx <= byte_idx + 2'd1;
                if (byte_idx == 2'd3) begin
                  cur_word <= next_word;
                  wa_q     <= wa_q + MEM_AW'(1);
                end
              end else begin
                bit_cnt <= bit_cnt + 5'd1;
              end
            end
          end
          S_IGNORE: spi_miso <= 1'b0;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
